fix_msg_tx: RTL and testbench
=============================

# fix_msg_tx

Transmit-side FIX session message serializer. The FIX engine's receive path parses the inbound byte stream from the TOE. This block does the opposite: on a single request it builds a complete outbound session-level FIX 4.2 message (Logon, Heartbeat, Logout, and optionally TestRequest) and streams it one byte per handshake toward the TX FIFO/TOE. It computes BodyLength, the MsgSeqNum, and the trailing CheckSum itself.

## Interface
Parameters:
- SENDER_ID, 32'h46495831 ("FIX1"): 4 ASCII chars for tag 49.
- TARGET_ID, 32'h45584348 ("EXCH"): 4 ASCII chars for tag 56.
- HB_INT, 16'h3330 ("30"): 2 ASCII digits for tag 108.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- send_i  in  1  request to send one message; sampled only in IDLE.
- msg_type_i  in  2  00 Logon(A), 01 Heartbeat(0), 10 Logout(5), 11 TestRequest(1).
- ready_i  in  1  downstream can accept a byte.
- message_o  out  8  current byte.
- send_message_valid_o  out  1  message_o is valid.
- busy_o  out  1  a message is in progress.
- done_o  out  1  one-cycle pulse after the last byte is accepted.
- seq_num_o  out  32  next MsgSeqNum as 8 BCD digits.

## Operation
- Message byte order, where | is SOH 8'h01:
  - `8=FIX.4.2|`
  - `9=LLL|`
  - `35=T|`
  - `34=SSSSSSSS|`
  - `49=<SENDER_ID>|`
  - `56=<TARGET_ID>|`
  - body extension:
    - Logon: `98=0|108=<HB_INT>|`
    - TestRequest: `112=TEST|`
    - Heartbeat and Logout: none
  - `10=CCC|`
- BodyLength LLL is 3 zero-padded decimal digits. It counts bytes from `35=` through the SOH before `10=`.
  - Heartbeat and Logout: 033 (total message 56 bytes).
  - Logon: 045 (68 bytes).
  - TestRequest: 042 (65 bytes).
- SSSSSSSS is the 8-digit zero-padded sequence number.
- CheckSum CCC is the sum modulo 256 of every byte before `10=`, written as 3 decimal digits.
  - Hundreds digit: 2 if the sum is at least 200, 1 if at least 100, else 0.
  - Tens and units digits come from the remainder.
- States:
  - IDLE: waiting. On send_i, capture msg_type_i, clear the byte index and checksum, go to EMIT.
  - EMIT: index walks the header and body. The checksum accumulates each byte accepted (valid && ready_i). After the final body SOH is accepted, go to TRAIL.
  - TRAIL: 7 bytes `10=CCC|`. CCC is frozen on entry. After the last byte is accepted, go to DONE.
  - DONE: one cycle. done_o=1, the sequence number increments, go to IDLE.
- Sequence number:
  - 8-digit BCD counter, reset value 00000001.
  - Increments only in DONE.
  - 99999999 wraps to 00000001; the value 00000000 is never emitted.

## Timing
- Reset values: send_message_valid_o=0, message_o=8'h00, busy_o=0, done_o=0, seq_num_o=32'h00000001, state IDLE.
- Start: send_i is accepted at an edge in IDLE. The first byte (`8`) with valid appears in the next cycle.
- Outputs are registered. Once valid is asserted, message_o and valid hold stable until ready_i=1. The block never withdraws a byte.
- With ready_i held at 1: one byte per cycle. An N-byte message occupies N cycles, followed by 1 DONE cycle.
- busy_o is 1 from the cycle after acceptance through the last byte, and 0 in DONE.
- Back-to-back operation: send_i is accepted in DONE's successor IDLE cycle. Minimum inter-message gap is 1 idle cycle plus DONE.
- send_i asserted while busy is ignored and not queued. msg_type_i changes mid-message have no effect.
- Asserting rst mid-message aborts immediately:
  - valid drops.
  - The sequence number returns to 1.
  - No done_o is produced.

## Configuration
- FIX_TX_TESTREQ_EN
  - Defined: msg_type 11 emits a TestRequest (`35=1`, `112=TEST|`, BodyLength 042).
  - Undefined: msg_type 11 is encoded as Heartbeat (`35=0`, BodyLength 033). No TestRequest byte logic is synthesized.

## Structure
- fix_pkg holds:
  - SOH constant.
  - msg_type enum.
  - BodyLength constants: 033, 045, 042.
  - Message-length constants: 56, 68, 65.
  - The state enum.
- Sub-module fix_tx_bcd_seq is the 8-digit BCD incrementer with wrap-to-1. The byte-select mux stays in the top level, indexed by state, index and type.

## Test plan
- Reset, then Heartbeat with ready_i=1:
  - 56 bytes starting `8=FIX.4.2|9=033|35=0|34=00000001|49=FIX1|56=EXCH|10=`.
  - CCC matches the bench's sum modulo 256.
  - done_o pulses once; seq_num_o becomes 00000002.
- Logon: 68 bytes, BodyLength 045, contains `98=0|108=30|`, checksum correct.
- Random ready_i stalls during a Logout:
  - Byte sequence identical to the no-stall run.
  - message_o stable while valid=1 and ready_i=0.
- send_i pulsed mid-message and msg_type_i toggled mid-message: no effect on the current message, no extra done_o.
- Force the sequence number to 99999999 and send:
  - Emitted `34=99999999`.
  - Next message shows `34=00000001`.
- rst asserted at byte 20:
  - Valid falls immediately.
  - The next Heartbeat emits `34=00000001`.
- msg_type 11: emits TestRequest with FIX_TX_TESTREQ_EN defined, and a Heartbeat without it.

Source files
------------

// File: rtl/fix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fix_pkg
// Purpose  : Shared types, constants and helpers for the FIX session TX path.
//            Optional TestRequest support: FIX_TX_TESTREQ_EN.
// Revision : 1.0
// ============================================================================
package fix_pkg;

    localparam logic [7:0] c_SOH = 8'h01;

    typedef enum logic [1:0] {
        MSG_LOGON     = 2'b00,
        MSG_HEARTBEAT = 2'b01,
        MSG_LOGOUT    = 2'b10,
        MSG_TESTREQ   = 2'b11
    } msg_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_TRAIL = 2'd2,
        S_DONE  = 2'd3
    } fix_state_e;

    localparam logic [23:0] c_BODY_LEN_SHORT   = "033";
    localparam logic [23:0] c_BODY_LEN_LOGON   = "045";
    localparam logic [23:0] c_BODY_LEN_TESTREQ = "042";

    localparam logic [6:0] c_MSG_LEN_SHORT   = 7'd56;
    localparam logic [6:0] c_MSG_LEN_LOGON   = 7'd68;
    localparam logic [6:0] c_MSG_LEN_TESTREQ = 7'd65;

    localparam logic [6:0] c_TRAIL_LEN = 7'd8;
    localparam logic [6:0] c_TRAIL_LAST = 7'd6;
    localparam logic [6:0] c_HDR_LAST = 7'd48;

    function automatic logic [6:0] msg_len(input msg_type_e t);
        case (t)
            MSG_LOGON:   return c_MSG_LEN_LOGON;
`ifdef FIX_TX_TESTREQ_EN
            MSG_TESTREQ: return c_MSG_LEN_TESTREQ;
`endif
            default:     return c_MSG_LEN_SHORT;
        endcase
    endfunction

    function automatic logic [23:0] body_len_ascii(input msg_type_e t);
        case (t)
            MSG_LOGON:   return c_BODY_LEN_LOGON;
`ifdef FIX_TX_TESTREQ_EN
            MSG_TESTREQ: return c_BODY_LEN_TESTREQ;
`endif
            default:     return c_BODY_LEN_SHORT;
        endcase
    endfunction

    function automatic logic [7:0] type_char(input msg_type_e t);
        case (t)
            MSG_LOGON:   return "A";
            MSG_LOGOUT:  return "5";
`ifdef FIX_TX_TESTREQ_EN
            MSG_TESTREQ: return "1";
`endif
            default:     return "0";
        endcase
    endfunction

    // Checksum byte rendered as three ASCII decimal digits.
    function automatic logic [23:0] dec3(input logic [7:0] v);
        logic [7:0] h;
        logic [7:0] r;
        logic [7:0] t;
        logic [7:0] u;
        if (v >= 8'd200) begin
            h = 8'd2;
            r = v - 8'd200;
        end else if (v >= 8'd100) begin
            h = 8'd1;
            r = v - 8'd100;
        end else begin
            h = 8'd0;
            r = v;
        end
        t = r / 8'd10;
        u = r - (t * 8'd10);
        return {8'h30 + h, 8'h30 + t, 8'h30 + u};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fix_tx_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : fix_tx_bcd_seq
// Purpose  : 8-digit BCD MsgSeqNum counter; 99999999 wraps to 00000001.
// Revision : 1.0
// ============================================================================
module fix_tx_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] seq_o
);

    logic [31:0] seq_q;
    logic [31:0] seq_d;
    logic [8:0]  w_carry;

    always_comb begin
        seq_d   = seq_q;
        w_carry = 9'd1;
        for (int k = 0; k < 8; k++) begin
            if (w_carry[k]) begin
                if (seq_q[4*k +: 4] == 4'd9) begin
                    seq_d[4*k +: 4] = 4'd0;
                    w_carry[k+1]    = 1'b1;
                end else begin
                    seq_d[4*k +: 4] = seq_q[4*k +: 4] + 4'd1;
                end
            end
        end
        // Zero is not a legal MsgSeqNum, so overflow restarts at one.
        if (w_carry[8]) begin
            seq_d = 32'h0000_0001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= 32'h0000_0001;
        end else if (inc_i) begin
            seq_q <= seq_d;
        end
    end

    assign seq_o = seq_q;

endmodule
`default_nettype wire

// File: rtl/fix_msg_tx.sv
`default_nettype none
// ============================================================================
// Module   : fix_msg_tx
// Purpose  : Serialises Logon/Heartbeat/Logout (and TestRequest when
//            FIX_TX_TESTREQ_EN is defined) FIX 4.2 messages one byte per beat.
// Revision : 1.0
// ============================================================================
module fix_msg_tx #(
    parameter logic [31:0] SENDER_ID = 32'h46495831,
    parameter logic [31:0] TARGET_ID = 32'h45584348,
    parameter logic [15:0] HB_INT    = 16'h3330
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_i,
    input  logic [1:0]  msg_type_i,
    input  logic        ready_i,
    output logic [7:0]  message_o,
    output logic        send_message_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] seq_num_o
);
    import fix_pkg::*;

    fix_state_e  state_q, state_d;
    msg_type_e   type_q, type_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  ccc_q, ccc_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [7:0]  byte_q;

    logic        w_acc;
    logic        w_load;
    logic        w_inc;
    logic [6:0]  w_body_last;
    msg_type_e   w_req_type;
    logic [7:0]  w_byte;
    logic [31:0] w_seq;

    fix_tx_bcd_seq u_seq (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_inc),
        .seq_o (w_seq)
    );

`ifdef FIX_TX_TESTREQ_EN
    assign w_req_type = msg_type_e'(msg_type_i);
`else
    assign w_req_type = (msg_type_i == 2'b11) ? MSG_HEARTBEAT : msg_type_e'(msg_type_i);
`endif

    assign w_acc       = valid_q & ready_i;
    assign w_body_last = msg_len(type_q) - c_TRAIL_LEN;
    assign w_inc       = (state_q == S_DONE);

    function automatic logic [7:0] sel_byte(input fix_state_e st, input logic [6:0] i,
                                            input msg_type_e t, input logic [7:0] cs,
                                            input logic [31:0] seq);
        logic [23:0] bl;
        logic [23:0] ccc;
        logic [7:0]  b;
        bl  = body_len_ascii(t);
        ccc = dec3(cs);
        b   = c_SOH;
        if (st == S_TRAIL) begin
            case (i)
                7'd0:    b = "1";
                7'd1:    b = "0";
                7'd2:    b = "=";
                7'd3:    b = ccc[23:16];
                7'd4:    b = ccc[15:8];
                7'd5:    b = ccc[7:0];
                default: b = c_SOH;
            endcase
        end else if (i <= c_HDR_LAST) begin
            case (i)
                7'd0:  b = "8";
                7'd1:  b = "=";
                7'd2:  b = "F";
                7'd3:  b = "I";
                7'd4:  b = "X";
                7'd5:  b = ".";
                7'd6:  b = "4";
                7'd7:  b = ".";
                7'd8:  b = "2";
                7'd10: b = "9";
                7'd11: b = "=";
                7'd12: b = bl[23:16];
                7'd13: b = bl[15:8];
                7'd14: b = bl[7:0];
                7'd16: b = "3";
                7'd17: b = "5";
                7'd18: b = "=";
                7'd19: b = type_char(t);
                7'd21: b = "3";
                7'd22: b = "4";
                7'd23: b = "=";
                7'd33: b = "4";
                7'd34: b = "9";
                7'd35: b = "=";
                7'd41: b = "5";
                7'd42: b = "6";
                7'd43: b = "=";
                default: begin
                    // Field values are laid out on aligned offsets so the low index bits pick the digit/char.
                    if (i inside {[7'd24:7'd31]})      b = {4'h3, seq[{~i[2:0], 2'b00} +: 4]};
                    else if (i inside {[7'd36:7'd39]}) b = SENDER_ID[{~i[1:0], 3'b000} +: 8];
                    else if (i inside {[7'd44:7'd47]}) b = TARGET_ID[{~i[1:0], 3'b000} +: 8];
                    else                               b = c_SOH;
                end
            endcase
        end else begin
            case (t)
                MSG_LOGON: begin
                    case (i)
                        7'd49:   b = "9";
                        7'd50:   b = "8";
                        7'd51:   b = "=";
                        7'd52:   b = "0";
                        7'd54:   b = "1";
                        7'd55:   b = "0";
                        7'd56:   b = "8";
                        7'd57:   b = "=";
                        7'd58:   b = HB_INT[15:8];
                        7'd59:   b = HB_INT[7:0];
                        default: b = c_SOH;
                    endcase
                end
`ifdef FIX_TX_TESTREQ_EN
                MSG_TESTREQ: begin
                    case (i)
                        7'd49:   b = "1";
                        7'd50:   b = "1";
                        7'd51:   b = "2";
                        7'd52:   b = "=";
                        7'd53:   b = "T";
                        7'd54:   b = "E";
                        7'd55:   b = "S";
                        7'd56:   b = "T";
                        default: b = c_SOH;
                    endcase
                end
`endif
                default: b = c_SOH;
            endcase
        end
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        ccc_d   = ccc_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        w_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_i) begin
                    state_d = S_EMIT;
                    type_d  = w_req_type;
                    idx_d   = 7'd0;
                    csum_d  = 8'd0;
                    valid_d = 1'b1;
                    w_load  = 1'b1;
                end
            end
            S_EMIT: begin
                if (w_acc) begin
                    csum_d = csum_q + byte_q;
                    w_load = 1'b1;
                    if (idx_q == w_body_last) begin
                        state_d = S_TRAIL;
                        idx_d   = 7'd0;
                        ccc_d   = csum_d;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_acc) begin
                    if (idx_q == c_TRAIL_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 7'd1;
                        w_load = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // The byte for the next beat is looked up from the post-handshake position.
    always_comb begin
        w_byte = sel_byte(state_d, idx_d, type_d, ccc_d, w_seq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= MSG_HEARTBEAT;
            idx_q   <= 7'd0;
            csum_q  <= 8'd0;
            ccc_q   <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            ccc_q   <= ccc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (w_load) begin
                byte_q <= w_byte;
            end else if (done_d) begin
                byte_q <= 8'h00;
            end
        end
    end

    assign message_o            = byte_q;
    assign send_message_valid_o = valid_q;
    assign busy_o               = valid_q;
    assign done_o               = done_q;
    assign seq_num_o            = w_seq;

endmodule
`default_nettype wire

// File: tb/tb_fix_msg_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fix_msg_tx
// Purpose  : Directed/randomised self-checking bench for fix_msg_tx.
// Revision : 1.0
// ============================================================================
module tb_fix_msg_tx;

    logic        clk;
    logic        rst;
    logic        send_i;
    logic [1:0]  msg_type_i;
    logic        ready_i;
    logic [7:0]  message_o;
    logic        send_message_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] seq_num_o;

    int total;
    int bad;
    int model_seq;
    int n_done;
    logic [7:0] rx_q[$];

    fix_msg_tx dut (
        .clk                  (clk),
        .rst                  (rst),
        .send_i               (send_i),
        .msg_type_i           (msg_type_i),
        .ready_i              (ready_i),
        .message_o            (message_o),
        .send_message_valid_o (send_message_valid_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .seq_num_o            (seq_num_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int n);
        logic [31:0] r;
        int v;
        r = '0;
        v = n;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference message assembled from the textual field layout.
    function automatic string build_msg(input logic [1:0] mt, input int seq);
        string tc;
        string ext;
        string body;
        string msg;
        int    sum;
        ext = "";
        case (mt)
            2'b00: begin tc = "A"; ext = $sformatf("98=0%c108=30%c", 8'h01, 8'h01); end
            2'b10: tc = "5";
`ifdef FIX_TX_TESTREQ_EN
            2'b11: begin tc = "1"; ext = $sformatf("112=TEST%c", 8'h01); end
`endif
            default: tc = "0";
        endcase
        body = $sformatf("35=%s%c34=%08d%c49=FIX1%c56=EXCH%c", tc, 8'h01, seq, 8'h01, 8'h01, 8'h01);
        body = {body, ext};
        msg  = {$sformatf("8=FIX.4.2%c9=%03d%c", 8'h01, body.len(), 8'h01), body};
        sum  = 0;
        for (int i = 0; i < msg.len(); i++) sum += int'(msg[i]);
        return {msg, $sformatf("10=%03d%c", sum % 256, 8'h01)};
    endfunction

    // Starts one message from an idle negedge and collects accepted bytes.
    task automatic run_msg(input logic [1:0] mt, input int stall_pct, input bit disturb,
                           input int abort_at, output int nd);
        int   cyc;
        bit   held;
        bit   fin;
        logic [7:0] held_byte;
        rx_q.delete();
        nd = 0; held = 0; fin = 0; cyc = 0; held_byte = '0;
        send_i = 1'b1; msg_type_i = mt; ready_i = 1'b0;
        @(negedge clk);
        send_i = 1'b0;
        check("first_valid", {31'd0, send_message_valid_o}, 32'd1);
        check("first_byte", {24'd0, message_o}, 32'h38);
        while (!fin && cyc < 3000) begin
            if (held) check("hold_stable", {23'd0, send_message_valid_o, message_o}, {23'd0, 1'b1, held_byte});
            held = 0;
            if (done_o) begin
                nd++;
                fin = 1;
                send_i = 1'b0;
                check("busy_in_done", {31'd0, busy_o}, 32'd0);
            end else if (abort_at >= 0 && rx_q.size() == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_valid", {31'd0, send_message_valid_o}, 32'd0);
                check("abort_seq", seq_num_o, 32'h0000_0001);
                check("abort_done", {31'd0, done_o}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                fin = 1;
            end else if (send_message_valid_o) begin
                ready_i = ($urandom_range(99) >= stall_pct);
                if (ready_i) rx_q.push_back(message_o);
                else begin held = 1; held_byte = message_o; end
            end
            if (disturb && !fin) begin
                send_i = 1'($urandom_range(1));
                msg_type_i = 2'($urandom_range(3));
            end
            @(negedge clk);
            cyc++;
        end
        check("completed", {31'd0, fin}, 32'd1);
        send_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            if (done_o) nd++;
            @(negedge clk);
        end
    endtask

    task automatic verify(input logic [1:0] mt, input int exp_len, input string tag);
        string exp;
        int    d;
        int    n;
        exp = build_msg(mt, model_seq);
        check({tag, "_len"}, rx_q.size(), exp_len);
        n = (rx_q.size() < exp.len()) ? rx_q.size() : exp.len();
        d = -1;
        for (int i = 0; i < n; i++) if (d < 0 && rx_q[i] !== exp[i]) d = i;
        if (d < 0 && rx_q.size() != exp.len()) d = n;
        total++;
        assert (d == -1) else begin
            bad++;
            $error("FAIL %s_bytes first_diff=%0d observed=%h expected=%h", tag, d,
                   (d < rx_q.size()) ? rx_q[d] : 8'hxx, (d < exp.len()) ? exp[d] : 8'hxx);
        end
        check({tag, "_done_cnt"}, n_done, 1);
        model_seq = (model_seq == 99999999) ? 1 : model_seq + 1;
        check({tag, "_seq_next"}, seq_num_o, to_bcd(model_seq));
    endtask

    initial begin
        total = 0; bad = 0; model_seq = 1;
        rst = 1'b1; send_i = 1'b0; msg_type_i = 2'b00; ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, send_message_valid_o}, 32'd0);
        check("rst_msg", {24'd0, message_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_seq", seq_num_o, 32'h0000_0001);
        rst = 1'b0;
        @(negedge clk);

        run_msg(2'b01, 0, 1'b0, -1, n_done);
        verify(2'b01, 56, "hb");

        run_msg(2'b00, 0, 1'b0, -1, n_done);
        verify(2'b00, 68, "logon");

        run_msg(2'b10, 40, 1'b0, -1, n_done);
        verify(2'b10, 56, "logout_stall");

        run_msg(2'b01, 20, 1'b1, -1, n_done);
        verify(2'b01, 56, "hb_disturb");

        run_msg(2'b00, 30, 1'b1, -1, n_done);
        verify(2'b00, 68, "logon_disturb");

`ifdef FIX_TX_TESTREQ_EN
        run_msg(2'b11, 0, 1'b0, -1, n_done);
        verify(2'b11, 65, "type11");
`else
        run_msg(2'b11, 0, 1'b0, -1, n_done);
        verify(2'b11, 56, "type11");
`endif

        force dut.u_seq.seq_q = 32'h9999_9999;
        @(negedge clk);
        release dut.u_seq.seq_q;
        @(negedge clk);
        model_seq = 99999999;
        check("forced_seq", seq_num_o, 32'h9999_9999);
        run_msg(2'b01, 10, 1'b0, -1, n_done);
        verify(2'b01, 56, "hb_seqmax");
        run_msg(2'b10, 0, 1'b0, -1, n_done);
        verify(2'b10, 56, "logout_wrap");

        run_msg(2'b01, 0, 1'b0, 20, n_done);
        check("abort_no_done", n_done, 0);
        check("abort_bytes", rx_q.size(), 20);
        model_seq = 1;
        run_msg(2'b01, 0, 1'b0, -1, n_done);
        verify(2'b01, 56, "hb_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
